// File: rtl/mac_tx_arbiter.sv
// mac_tx_arbiter: frame-level arbiter sharing the MAC TX payload byte stream
// among NUM_SRC producers. A grant is held until the owner's eof byte is
// accepted, so frames never interleave.
//
// Build option: define MAC_TX_ARB_STRICT_PRIO_EN to select the lowest-index
// requester instead of round-robin (source 0 can then starve the others).
//
// Handshake: a byte moves on a cycle where valid && ready are both high.
// Valid never waits on ready; ready may depend combinationally on valid only
// through the grant (src_ready[g] is a straight copy of mac_ready).
module mac_tx_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int IDW     = $clog2(NUM_SRC)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_SRC-1:0]   src_valid,
    input  logic [NUM_SRC*8-1:0] src_data,
    input  logic [NUM_SRC-1:0]   src_eof,
    output logic [NUM_SRC-1:0]   src_ready,
    input  logic                 mac_ready,
    output logic                 mac_valid,
    output logic [7:0]           mac_data,
    output logic                 mac_eof,
    output logic                 busy,
    output logic [IDW-1:0]       grant_id,
    output logic                 frame_done
);

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t         state;
    logic [IDW-1:0] winner;
    logic           any_req;
    logic           accept;

`ifdef MAC_TX_ARB_STRICT_PRIO_EN
    // Lowest-index requester wins.
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!any_req && src_valid[i]) begin
                winner  = IDW'(i);
                any_req = 1'b1;
            end
        end
    end
`else
    localparam int            CW    = IDW + 1;
    localparam logic [CW-1:0] NUM_C = CW'(NUM_SRC);

    logic [IDW-1:0] last;
    logic [CW-1:0]  cand;

    // First requester searching upward from last+1; one extra bit plus an
    // explicit wrap keeps the search correct for non-power-of-two NUM_SRC.
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        cand    = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            cand = {1'b0, last} + CW'(k);
            if (cand >= NUM_C) begin
                cand = cand - NUM_C;
            end
            if (!any_req && src_valid[cand[IDW-1:0]]) begin
                winner  = cand[IDW-1:0];
                any_req = 1'b1;
            end
        end
    end
`endif

    // Combinational byte path from the granted source; gated while idle.
    always_comb begin
        src_ready = '0;
        mac_valid = 1'b0;
        mac_data  = 8'h00;
        mac_eof   = 1'b0;
        if (state == XFER) begin
            mac_valid           = src_valid[grant_id];
            mac_data            = src_data[{grant_id, 3'b000} +: 8];
            mac_eof             = src_eof[grant_id];
            src_ready[grant_id] = mac_ready;
        end
    end

    assign accept     = mac_valid & mac_ready;
    assign frame_done = accept & mac_eof;

    // Grant FSM: arbitrate in IDLE, hold the grant in XFER until eof is taken.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            grant_id <= '0;
            busy     <= 1'b0;
`ifndef MAC_TX_ARB_STRICT_PRIO_EN
            last     <= IDW'(NUM_SRC - 1);
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_id <= winner;
`ifndef MAC_TX_ARB_STRICT_PRIO_EN
                        last     <= winner;
`endif
                        busy     <= 1'b1;
                        state    <= XFER;
                    end
                end
                XFER: begin
                    if (accept && mac_eof) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_tx_arbiter.sv
// tb_mac_tx_arbiter: vector table for single-cycle behaviour plus queue-based
// source models and a byte scoreboard for the multi-frame sequences.
module tb_mac_tx_arbiter;

    localparam int NUM = 4;
    localparam int IDW = 2;
    localparam int EW  = IDW + 9;   // {grant id, eof, data}

    logic             clk;
    logic             reset;
    logic [NUM-1:0]   src_valid;
    logic [NUM*8-1:0] src_data;
    logic [NUM-1:0]   src_eof;
    logic [NUM-1:0]   src_ready;
    logic             mac_ready;
    logic             mac_valid;
    logic [7:0]       mac_data;
    logic             mac_eof;
    logic             busy;
    logic [IDW-1:0]   grant_id;
    logic             frame_done;

    mac_tx_arbiter #(.NUM_SRC(NUM)) dut (
        .clk        (clk),
        .reset      (reset),
        .src_valid  (src_valid),
        .src_data   (src_data),
        .src_eof    (src_eof),
        .src_ready  (src_ready),
        .mac_ready  (mac_ready),
        .mac_valid  (mac_valid),
        .mac_data   (mac_data),
        .mac_eof    (mac_eof),
        .busy       (busy),
        .grant_id   (grant_id),
        .frame_done (frame_done)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard state
    logic [EW-1:0] exp_q[$];
    logic [8:0]    src_q[NUM][$];
    logic [NUM-1:0] gap;
    int  n_cmp = 0;
    int  n_err = 0;
    bit  bfm_en = 1'b0;
    bit  sb_en  = 1'b0;
    logic           s_busy;
    logic           s_valid;
    logic [IDW-1:0] s_gid;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_srcs();
        logic [8:0] f;
        for (int i = 0; i < NUM; i++) begin
            if (src_q[i].size() > 0 && !gap[i]) begin
                f = src_q[i][0];
                src_valid[i]       = 1'b1;
                src_data[i*8 +: 8] = f[7:0];
                src_eof[i]         = f[8];
            end else begin
                src_valid[i]       = 1'b0;
                src_data[i*8 +: 8] = 8'h00;
                src_eof[i]         = 1'b0;
            end
        end
    endtask

    task automatic push_frame(input int s, input int len, input logic [7:0] base);
        logic [8:0] ent;
        for (int b = 0; b < len; b++) begin
            ent = {(b == len - 1), base + 8'(b)};
            src_q[s].push_back(ent);
            exp_q.push_back({IDW'(s), ent});
        end
        drive_srcs();
    endtask

    // One clock: sample mid-cycle, score accepted bytes, advance source queues.
    task automatic tick();
        logic [NUM-1:0] acc;
        logic [EW-1:0]  e;
        #2;
        s_busy  = busy;
        s_valid = mac_valid;
        s_gid   = grant_id;
        acc     = src_valid & src_ready;
        if (sb_en) begin
            if (mac_valid && mac_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", {21'd0, grant_id, mac_eof, mac_data}, 32'hFFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_byte", {21'd0, grant_id, mac_eof, mac_data}, {21'd0, e});
                end
            end
            check("frame_done", {31'd0, frame_done}, {31'd0, mac_valid & mac_ready & mac_eof});
        end
        @(posedge clk);
        #1;
        if (bfm_en) begin
            for (int i = 0; i < NUM; i++) begin
                if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            end
            drive_srcs();
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int i = 0; i < NUM; i++) src_q[i].delete();
        exp_q.delete();
        gap       = '0;
        src_valid = '0;
        src_data  = '0;
        src_eof   = '0;
        mac_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic run_until_empty(input string name, input int max, output int n, output int idle);
        n = 0;
        idle = 0;
        while (exp_q.size() > 0 && n < max) begin
            tick();
            n++;
            if (!s_busy) idle++;
        end
        check({name, "_drained"}, exp_q.size(), 0);
    endtask

    // Vector table
    typedef struct {
        logic        rst;
        int          src;
        logic        v;
        logic [7:0]  d;
        logic        e;
        logic        r;
        logic [17:0] exp;   // {busy, mac_valid, mac_data, mac_eof, frame_done, src_ready, grant_id}
    } vec_t;

    vec_t vecs[14];

    function automatic logic [17:0] mk(input logic b, input logic mv, input logic [7:0] md,
                                       input logic me, input logic fd, input logic [3:0] sr,
                                       input logic [1:0] g);
        return {b, mv, md, me, fd, sr, g};
    endfunction

    task automatic set_vec(input int k, input logic rst, input int src, input logic v,
                           input logic [7:0] d, input logic e, input logic r, input logic [17:0] x);
        vecs[k].rst = rst;
        vecs[k].src = src;
        vecs[k].v   = v;
        vecs[k].d   = d;
        vecs[k].e   = e;
        vecs[k].r   = r;
        vecs[k].exp = x;
    endtask

    int n_cyc;
    int n_idle;

    initial begin
        reset     = 1'b1;
        src_valid = '0;
        src_data  = '0;
        src_eof   = '0;
        mac_ready = 1'b1;
        gap       = '0;

        // Single source 2: AA, BB, CC(eof)
        set_vec(0,  1'b1, 2, 1'b1, 8'hAA, 1'b0, 1'b1, mk(0, 0, 8'h00, 0, 0, 4'b0000, 2'd0));
        set_vec(1,  1'b0, 2, 1'b1, 8'hAA, 1'b0, 1'b1, mk(1, 1, 8'hAA, 0, 0, 4'b0100, 2'd2));
        set_vec(2,  1'b0, 2, 1'b1, 8'hBB, 1'b0, 1'b1, mk(1, 1, 8'hBB, 0, 0, 4'b0100, 2'd2));
        set_vec(3,  1'b0, 2, 1'b1, 8'hCC, 1'b1, 1'b1, mk(1, 1, 8'hCC, 1, 1, 4'b0100, 2'd2));
        set_vec(4,  1'b0, 2, 1'b0, 8'h00, 1'b0, 1'b1, mk(0, 0, 8'h00, 0, 0, 4'b0000, 2'd2));
        // Back-pressure on a 4-byte frame from source 1
        set_vec(5,  1'b1, 1, 1'b1, 8'h11, 1'b0, 1'b1, mk(0, 0, 8'h00, 0, 0, 4'b0000, 2'd0));
        set_vec(6,  1'b0, 1, 1'b1, 8'h11, 1'b0, 1'b1, mk(1, 1, 8'h11, 0, 0, 4'b0010, 2'd1));
        set_vec(7,  1'b0, 1, 1'b1, 8'h22, 1'b0, 1'b0, mk(1, 1, 8'h22, 0, 0, 4'b0000, 2'd1));
        set_vec(8,  1'b0, 1, 1'b1, 8'h22, 1'b0, 1'b1, mk(1, 1, 8'h22, 0, 0, 4'b0010, 2'd1));
        set_vec(9,  1'b0, 1, 1'b1, 8'h33, 1'b0, 1'b0, mk(1, 1, 8'h33, 0, 0, 4'b0000, 2'd1));
        set_vec(10, 1'b0, 1, 1'b1, 8'h33, 1'b0, 1'b1, mk(1, 1, 8'h33, 0, 0, 4'b0010, 2'd1));
        set_vec(11, 1'b0, 1, 1'b1, 8'h44, 1'b1, 1'b0, mk(1, 1, 8'h44, 1, 0, 4'b0000, 2'd1));
        set_vec(12, 1'b0, 1, 1'b1, 8'h44, 1'b1, 1'b1, mk(1, 1, 8'h44, 1, 1, 4'b0010, 2'd1));
        set_vec(13, 1'b0, 1, 1'b0, 8'h00, 1'b0, 1'b1, mk(0, 0, 8'h00, 0, 0, 4'b0000, 2'd1));

        // Reset state
        do_reset();
        #2;
        check("reset_state", {26'd0, busy, mac_valid, src_ready, grant_id},
              {26'd0, 1'b0, 1'b0, 4'b0000, 2'd0});
        check("reset_frame_done", {31'd0, frame_done}, 32'd0);
        @(posedge clk);
        #1;

        // Table-driven single-cycle vectors
        for (int k = 0; k < 14; k++) begin
            if (vecs[k].rst) do_reset();
            src_valid = '0;
            src_data  = '0;
            src_eof   = '0;
            src_valid[vecs[k].src]         = vecs[k].v;
            src_data[vecs[k].src*8 +: 8]   = vecs[k].d;
            src_eof[vecs[k].src]           = vecs[k].e;
            mac_ready = vecs[k].r;
            #2;
            check($sformatf("vec%0d", k),
                  {14'd0, busy, mac_valid, mac_data, mac_eof, frame_done, src_ready, grant_id},
                  {14'd0, vecs[k].exp});
            @(posedge clk);
            #1;
        end

        // Fairness: all four sources, two 2-byte frames each
        bfm_en = 1'b1;
        sb_en  = 1'b1;
        do_reset();
`ifdef MAC_TX_ARB_STRICT_PRIO_EN
        for (int s = 0; s < NUM; s++)
            for (int r = 0; r < 2; r++) push_frame(s, 2, 8'(s * 16 + r * 4));
`else
        for (int r = 0; r < 2; r++)
            for (int s = 0; s < NUM; s++) push_frame(s, 2, 8'(s * 16 + r * 4));
`endif
        run_until_empty("rr", 200, n_cyc, n_idle);
        check("rr_cycles", n_cyc, 24);
        check("rr_idle_cycles", n_idle, 8);

        // Mid-frame gap on source 3 while source 0 requests
        do_reset();
        push_frame(3, 4, 8'h30);
        tick();
        push_frame(0, 2, 8'h50);
        tick();
        tick();
        gap[3] = 1'b1;
        drive_srcs();
        for (int c = 0; c < 5; c++) begin
            tick();
            check("gap_hold", {29'd0, s_busy, s_valid, s_gid}, {29'd0, 1'b1, 1'b0, 2'd3});
        end
        gap[3] = 1'b0;
        drive_srcs();
        run_until_empty("gap", 100, n_cyc, n_idle);

        // Reset during byte 2 of a source-1 frame
        do_reset();
        push_frame(1, 4, 8'h60);
        tick();
        tick();
        sb_en = 1'b0;
        reset = 1'b1;
        tick();
        for (int i = 0; i < NUM; i++) src_q[i].delete();
        exp_q.delete();
        drive_srcs();
        #2;
        check("rst_mid_frame", {26'd0, busy, mac_valid, src_ready}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb_en = 1'b1;
        push_frame(0, 2, 8'h70);
        push_frame(1, 2, 8'h80);
        run_until_empty("post_rst", 100, n_cyc, n_idle);

        // Sources 0 and 2 requesting continuously
        do_reset();
`ifdef MAC_TX_ARB_STRICT_PRIO_EN
        push_frame(0, 2, 8'h90);
        push_frame(0, 2, 8'h94);
        push_frame(0, 2, 8'h98);
        push_frame(2, 2, 8'hA0);
`else
        push_frame(0, 2, 8'h90);
        push_frame(2, 2, 8'hA0);
        push_frame(0, 2, 8'h94);
        push_frame(0, 2, 8'h98);
`endif
        run_until_empty("prio", 100, n_cyc, n_idle);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mac_tx_arbiter.md
# mac_tx_arbiter

Frame-level round-robin arbiter that shares the MAC TX payload byte stream (ready/valid/data/eof) among `NUM_SRC` independent producers. It sits directly upstream of the MAC TX payload input. Once a source is granted, the grant is held until that source's `eof` byte is accepted, so frames are never interleaved. Status outputs report the current owner and pulse on every completed frame.

## Interface
Parameters:
- `NUM_SRC`, default 4: number of requesting sources, 2..8.
- `IDW`, default `$clog2(NUM_SRC)`: width of the grant index.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `src_valid`  in  NUM_SRC  per-source byte valid; also acts as the request.
- `src_data`  in  NUM_SRC*8  per-source byte; source i occupies `[i*8+:8]`.
- `src_eof`  in  NUM_SRC  per-source last-byte flag.
- `src_ready`  out  NUM_SRC  per-source ready; at most one bit is high.
- `mac_ready`  in  1  ready from the MAC TX payload input.
- `mac_valid`  out  1  valid to the MAC.
- `mac_data`  out  8  byte to the MAC.
- `mac_eof`  out  1  eof to the MAC.
- `busy`  out  1  high while in XFER.
- `grant_id`  out  IDW  index of the current or most recent owner.
- `frame_done`  out  1  one-cycle pulse per accepted eof byte.

## Operation
- State machine has two states, IDLE and XFER.
- **IDLE**
  - Output path is gated: `mac_valid=0` and `src_ready=0`.
  - When any `src_valid` bit is high, select the first requester searching upward from `last+1` (modulo `NUM_SRC`).
  - Register the winner into `grant_id` and `last`, then go to XFER.
  - If no source is requesting, stay in IDLE.
- **XFER**
  - The path is combinational from the granted source: `mac_valid=src_valid[g]`, `mac_data=src_data[g]`, `mac_eof=src_eof[g]`, `src_ready[g]=mac_ready`.
  - All other `src_ready` bits are 0.
  - A byte is accepted when `mac_valid && mac_ready`.
  - When the accepted byte has `mac_eof` set: pulse `frame_done` in that cycle and go to IDLE.
- A granted source that drops `src_valid` mid-frame keeps the grant. The arbiter waits indefinitely; no timeout exists.
- Requests from other sources during XFER are ignored until the grant returns to IDLE.
- A one-byte frame (eof on the first byte) is legal: XFER lasts one accepted cycle.
- **Reset values:** state IDLE, `grant_id=0`, `last=NUM_SRC-1` (so source 0 has first priority), `busy=0`, `frame_done=0`, `mac_valid=0`, `src_ready=0`.
- Reset mid-frame abandons the frame; no eof is generated. The MAC-side recovery is outside this block.
- The priority search uses `IDW+1`-bit arithmetic with explicit modulo, so it is correct for non-power-of-two `NUM_SRC`.

## Timing
- Arbitration latency: a request seen in IDLE at cycle N gives `busy=1` at N+1. The first byte can be accepted at N+1.
- Frame turnaround: eof accepted at cycle M gives IDLE at M+1. The next frame's first byte is accepted at M+2 at the earliest, so there is a fixed 1-cycle bubble between frames.
- The data path adds zero cycles of latency (combinational mux). `mac_ready` to `src_ready` is a pure combinational path.
- `frame_done` is coincident with the eof handshake cycle.
- `grant_id` changes only on the IDLE→XFER transition.

## Configuration
- Macro: `MAC_TX_ARB_STRICT_PRIO_EN`.
- When defined, IDLE selects the lowest-index requesting source; `last` is unused. Source 0 can starve the others.
- When undefined, round-robin as above. This is the default build.
- Hold-until-eof and all timing are identical in both builds.

## Test plan
- **Single source:** source 2 sends a 3-byte frame `0xAA,0xBB,0xCC(eof)` with `mac_ready=1`.
  - Expect `busy` at cycle 1 and bytes on `mac_data` at cycles 1–3.
  - Expect `frame_done` at cycle 3, `grant_id=2`, and IDLE at cycle 4.
- **Round-robin fairness:** sources 0–3 each continuously request 2-byte frames.
  - Expect grant order 0,1,2,3,0,…
  - Expect exactly one idle cycle between frames and no interleaved bytes.
- **Back-pressure:** `mac_ready` toggles 1,0,1,0 during a 4-byte frame from source 1.
  - Expect `src_ready[1]` to mirror `mac_ready` and each byte to appear exactly once.
  - Expect other `src_ready` bits to stay 0 throughout.
- **Mid-frame gap:** source 3 drops valid for 5 cycles mid-frame while source 0 requests.
  - Expect the grant to stay on 3 and `mac_valid=0` during the gap.
  - Expect source 0 to be granted only after source 3's eof is accepted.
- **Reset mid-frame:** assert reset during byte 2 of a source-1 frame.
  - Expect next-cycle `busy=0`, `mac_valid=0`, and `src_ready=0`.
  - After reset, source 0 wins when 0 and 1 request simultaneously.
- **Strict priority** (`MAC_TX_ARB_STRICT_PRIO_EN` defined): sources 0 and 2 request continuously.
  - Expect every grant to go to 0 and source 2 never granted.
